// File: rtl/mem_fabric_pkg.sv
// Shared types and helpers for the memory bus fabric.
// Optional abort-on-stall behaviour is enabled with MEM_FABRIC_TIMEOUT_EN.
package mem_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } fabric_state_t;

  // Cause of the last completed transaction, kept for debug visibility.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_RO       = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_cause_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_fabric_decode.sv
// Region decode: region index -> one-hot target, unmapped flag, read-only violation.
import mem_fabric_pkg::*;

module mem_fabric_decode #(
  parameter int                    NUM_SLAVES  = 4,
  parameter int                    REGION_BITS = 2,
  parameter logic [NUM_SLAVES-1:0] RO_MASK     = '0
) (
  input  logic [REGION_BITS-1:0] region,
  input  logic                   write,
  output logic [NUM_SLAVES-1:0]  sel,
  output logic                   unmapped,
  output logic                   ro_violation
);

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
    assign sel[i] = (region == REGION_BITS'(i));
  end

  // Indices past the last slave match no select line.
  assign unmapped     = ~|sel;
  assign ro_violation = write & (|(sel & RO_MASK));

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-outstanding memory-mapped interconnect from the load/store port to NUM_SLAVES targets.
// Define MEM_FABRIC_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without slave ready.
import mem_fabric_pkg::*;

module mem_bus_fabric #(
  parameter int                    DATA_W         = 32,
  parameter int                    ADDR_W         = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    REGION_LSB     = 14,
  parameter int                    REGION_BITS    = 2,
  parameter logic [NUM_SLAVES-1:0] RO_MASK        = '0,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_error,
  output logic [NUM_SLAVES-1:0]        slv_sel,
  output logic                         slv_write,
  output logic [ADDR_W-1:0]            slv_addr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [NUM_SLAVES-1:0]        slv_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata
);

  fabric_state_t           state_q, state_d;
  err_cause_t              err_q;
  logic [DATA_W-1:0]       rdata_q, rd_mux;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_unmapped, dec_ro;
  logic                    accept, bad_req, hit, tmo_hit;

  mem_fabric_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .REGION_BITS (REGION_BITS),
    .RO_MASK     (RO_MASK)
  ) u_decode (
    .region       (req_addr[REGION_LSB +: REGION_BITS]),
    .write        (req_write),
    .sel          (dec_sel),
    .unmapped     (dec_unmapped),
    .ro_violation (dec_ro)
  );

  assign accept  = (state_q == IDLE) && req_valid;
  assign bad_req = dec_unmapped | dec_ro;
  // slv_sel is one-hot in ACCESS, so it doubles as the ready/rdata select.
  assign hit     = (state_q == ACCESS) && (|(slv_sel & slv_ready));

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (slv_sel[i]) rd_mux = rd_mux | slv_rdata[i*DATA_W +: DATA_W];
  end

`ifdef MEM_FABRIC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state_q == ACCESS) && !hit && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || state_q != ACCESS) tmo_cnt <= '0;
    else                            tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = bad_req ? RESP : ACCESS;
      ACCESS:  if (hit || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slv_sel   <= '0;
      slv_write <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_NONE;
    end else begin
      if (accept) begin
        slv_write <= req_write;
        slv_addr  <= req_addr;
        slv_wdata <= req_wdata;
        if (bad_req) begin
          slv_sel <= '0;
          rdata_q <= '0;
          err_q   <= dec_unmapped ? ERR_UNMAPPED : ERR_RO;
        end else begin
          slv_sel <= dec_sel;
        end
      end
      if (hit) begin
        slv_sel <= '0;
        rdata_q <= slv_write ? '0 : rd_mux;
        err_q   <= ERR_NONE;
      end else if (tmo_hit) begin
        slv_sel <= '0;
        rdata_q <= '0;
        err_q   <= ERR_TIMEOUT;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = (err_q != ERR_NONE);

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench: dut_a uses the default 4-slave map, dut_b has 3 slaves with region 1 read-only.
module tb_mem_bus_fabric;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req_write;
  logic [31:0] req_addr, req_wdata;

  logic         valid_a, ready_a, rsp_valid_a, rsp_error_a, slv_write_a;
  logic [31:0]  rsp_rdata_a, slv_addr_a, slv_wdata_a;
  logic [3:0]   slv_sel_a, slv_ready_a;
  logic [127:0] slv_rdata_a;

  logic         valid_b, ready_b, rsp_valid_b, rsp_error_b, slv_write_b;
  logic [31:0]  rsp_rdata_b, slv_addr_b, slv_wdata_b;
  logic [2:0]   slv_sel_b, slv_ready_b;
  logic [95:0]  slv_rdata_b;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_fabric #(.TIMEOUT_CYCLES(8)) dut_a (
    .clock(clock), .reset(reset),
    .req_valid(valid_a), .req_ready(ready_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_error(rsp_error_a),
    .slv_sel(slv_sel_a), .slv_write(slv_write_a), .slv_addr(slv_addr_a),
    .slv_wdata(slv_wdata_a), .slv_ready(slv_ready_a), .slv_rdata(slv_rdata_a)
  );

  mem_bus_fabric #(.NUM_SLAVES(3), .RO_MASK(3'b010), .TIMEOUT_CYCLES(8)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(valid_b), .req_ready(ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_error(rsp_error_b),
    .slv_sel(slv_sel_b), .slv_write(slv_write_b), .slv_addr(slv_addr_b),
    .slv_wdata(slv_wdata_b), .slv_ready(slv_ready_b), .slv_rdata(slv_rdata_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0;
    slv_ready_a = '0; slv_ready_b = '0;
    slv_rdata_a = '0; slv_rdata_b = '0;
    tick(2);
    reset = 1'b0;
    // reset state
    chk("rst_req_ready", ready_a, 1);
    chk("rst_rsp_valid", rsp_valid_a, 0);
    chk("rst_rsp_error", rsp_error_a, 0);
    chk("rst_rsp_rdata", rsp_rdata_a, 0);
    chk("rst_slv_sel",   slv_sel_a, 0);
    chk("rst_slv_addr",  slv_addr_a, 0);

    // 1: load region 0, slave ready in the strobe cycle
    slv_rdata_a[31:0] = 32'hDEADBEEF;
    req_addr = 32'h0000_0010; req_write = 1'b0; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    chk("t1_sel", slv_sel_a, 4'b0001);
    chk("t1_no_rsp_yet", rsp_valid_a, 0);
    slv_ready_a = 4'b0001;
    tick();
    slv_ready_a = '0;
    chk("t1_rsp_valid", rsp_valid_a, 1);
    chk("t1_rdata", rsp_rdata_a, 32'hDEADBEEF);
    chk("t1_error", rsp_error_a, 0);
    chk("t1_sel_clr", slv_sel_a, 0);
    chk("t1_ready_low", ready_a, 0);
    tick();
    chk("t1_rsp_pulse", rsp_valid_a, 0);
    chk("t1_rdata_hold", rsp_rdata_a, 32'hDEADBEEF);
    chk("t1_ready_back", ready_a, 1);

    // 2: store to region 3, five wait cycles, stray ready from slave 0 ignored
    slv_rdata_a[127:96] = 32'hFFFF_0000;
    req_addr = 32'h0000_C004; req_wdata = 32'h1234_5678; req_write = 1'b1; valid_a = 1'b1;
    tick();
    valid_a = 1'b0; req_wdata = '0;
    chk("t2_wdata", slv_wdata_a, 32'h1234_5678);
    chk("t2_write", slv_write_a, 1);
    chk("t2_addr",  slv_addr_a, 32'h0000_C004);
    slv_ready_a = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_sel_wait%0d", i), {slv_sel_a, rsp_valid_a}, {4'b1000, 1'b0});
      tick();
    end
    chk("t2_sel_last", slv_sel_a, 4'b1000);
    slv_ready_a = 4'b1001;
    tick();
    slv_ready_a = '0;
    chk("t2_rsp_valid", rsp_valid_a, 1);
    chk("t2_error", rsp_error_a, 0);
    chk("t2_rdata_write", rsp_rdata_a, 0);
    chk("t2_sel_clr", slv_sel_a, 0);
    tick();

    // region index aliases: 0x0001_4000 -> region 1
    slv_rdata_a[63:32] = 32'h0BAD_F00D;
    req_addr = 32'h0001_4000; req_write = 1'b0; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    chk("alias_sel", slv_sel_a, 4'b0010);
    slv_ready_a = 4'b0010;
    tick();
    slv_ready_a = '0;
    chk("alias_rdata", {rsp_valid_a, rsp_rdata_a}, {1'b1, 32'h0BAD_F00D});
    tick();

    // 4: read-only region 1 on dut_b: store errors, load succeeds
    slv_rdata_b[63:32] = 32'hA5A5_0001;
    req_addr = 32'h0000_4000; req_write = 1'b1; req_wdata = 32'h5555_AAAA; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    chk("t4_ro_sel", slv_sel_b, 0);
    chk("t4_ro_rsp", {rsp_valid_b, rsp_error_b}, 2'b11);
    chk("t4_ro_rdata", rsp_rdata_b, 0);
    tick();
    req_write = 1'b0; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    chk("t4_ld_sel", slv_sel_b, 3'b010);
    slv_ready_b = 3'b010;
    tick();
    slv_ready_b = '0;
    chk("t4_ld_rsp", {rsp_valid_b, rsp_error_b}, 2'b10);
    chk("t4_ld_rdata", rsp_rdata_b, 32'hA5A5_0001);
    tick();

    // 3: unmapped region 3 on the 3-slave fabric
    req_addr = 32'h0000_C000; req_write = 1'b0; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    chk("t3_sel", slv_sel_b, 0);
    chk("t3_rsp", {rsp_valid_b, rsp_error_b}, 2'b11);
    chk("t3_rdata", rsp_rdata_b, 0);
    tick();
    chk("t3_idle", {rsp_valid_b, ready_b}, 2'b01);

    // 5: reset while slave 1 stalls
    req_addr = 32'h0000_4000; req_write = 1'b0; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    chk("t5_sel", slv_sel_a, 4'b0010);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_sel_drop", slv_sel_a, 0);
    chk("t5_no_rsp", rsp_valid_a, 0);
    reset = 1'b0;
    tick();
    chk("t5_after", {rsp_valid_a, ready_a}, 2'b01);
    chk("t5_addr_clr", slv_addr_a, 0);

    // 6: slave 2 never ready
    req_addr = 32'h0000_8000; req_write = 1'b0; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
`ifdef MEM_FABRIC_TIMEOUT_EN
    tick(7);
    chk("t6_before_tmo", {slv_sel_a, rsp_valid_a}, {4'b0100, 1'b0});
    tick();
    chk("t6_tmo_rsp", {rsp_valid_a, rsp_error_a}, 2'b11);
    chk("t6_tmo_rdata", rsp_rdata_a, 0);
    chk("t6_tmo_sel", slv_sel_a, 0);
    tick();
    chk("t6_idle", ready_a, 1);
`else
    begin
      int bad = 0;
      for (int i = 0; i < 1000; i++) begin
        if (slv_sel_a !== 4'b0100 || rsp_valid_a !== 1'b0) bad++;
        tick();
      end
      chk("t6_still_waiting", bad, 0);
    end
    chk("t6_sel_held", slv_sel_a, 4'b0100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_recover", {slv_sel_a, ready_a}, {4'b0000, 1'b1});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
